// File: rtl/tstamp_serial_readout.sv
// Serial readout of the timestamp FIFO.
// Pops one word at a time, frames it as header + data (MSB first) + even
// parity, and shifts the frame out on a single pad with a frame strobe.
// All outputs are registered; the output process computes their next values
// from the next state so each output lines up with the state it describes.
module tstamp_serial_readout #(
    parameter int                  WORDWIDTH = 16,
    parameter int                  HDR_WIDTH = 4,
    parameter logic [HDR_WIDTH-1:0] HEADER   = 4'b1011,
    parameter int                  READ_LAT  = 1,
    parameter int                  BITDIV    = 1,
    parameter int                  GAP_BITS  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable_i,
    input  logic [WORDWIDTH-1:0] fifo_data_i,
    input  logic                 fifo_empty_i,
    output logic                 fifo_re_o,
    output logic                 ser_o,
    output logic                 frame_o,
    output logic                 busy_o,
    output logic [15:0]          frame_cnt_o
);

    // Whole frame lives in one shift register: header, data word, parity.
    localparam int FW  = HDR_WIDTH + WORDWIDTH + 1;
    localparam int BIW = $clog2(FW + 1);
    localparam int TW  = 8;

    localparam logic [BIW-1:0] LAST_BIT   = BIW'(FW - 1);
    localparam logic [BIW-1:0] DATA_FIRST = BIW'(HDR_WIDTH);
    localparam logic [BIW-1:0] PAR_IDX    = BIW'(FW - 1);

    localparam logic [TW-1:0] WAIT_LAST = TW'(READ_LAT - 1);
    localparam logic [TW-1:0] DIV_LAST  = TW'(BITDIV - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_BITS * BITDIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_HDR,
        S_DATA,
        S_PAR,
        S_GAP
    } state_t;

    state_t         state_q, state_d;
    logic [TW-1:0]  tmr_q, tmr_d;      // read-latency, bit-divider and gap timer
    logic [BIW-1:0] bit_q, bit_d;      // index of the frame bit on the pad
    logic [FW-1:0]  sr_q, sr_d;        // frame shift register, MSB goes out first

    logic           fifo_re_q, fifo_re_d;
    logic           ser_q, ser_d;
    logic           frame_q, frame_d;
    logic           busy_q, busy_d;
    logic [15:0]    frame_cnt_q, frame_cnt_d;

    // State and datapath registers; reset returns everything to idle and drops any popped word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tmr_q       <= '0;
            bit_q       <= '0;
            sr_q        <= '0;
            fifo_re_q   <= 1'b0;
            ser_q       <= 1'b0;
            frame_q     <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            bit_q       <= bit_d;
            sr_q        <= sr_d;
            fifo_re_q   <= fifo_re_d;
            ser_q       <= ser_d;
            frame_q     <= frame_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Next-state logic: pop, wait out the read latency, capture, then walk the frame bits.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        case (state_q)
            S_IDLE: begin
                if (enable_i && !fifo_empty_i) begin
                    state_d = S_RD;
                end
            end
            S_RD: begin
                state_d = S_WAIT;
                tmr_d   = WAIT_LAST;
            end
            S_WAIT: begin
                if (tmr_q == '0) begin
                    // Only sampling point of the FIFO data bus.
                    sr_d    = {HEADER, fifo_data_i, ^fifo_data_i};
                    bit_d   = '0;
                    tmr_d   = DIV_LAST;
                    state_d = S_HDR;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_HDR, S_DATA, S_PAR: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - 1'b1;
                end else begin
                    tmr_d = DIV_LAST;
                    sr_d  = sr_q << 1;
                    bit_d = bit_q + 1'b1;
                    if (bit_q == LAST_BIT) begin
                        state_d = S_GAP;
                        tmr_d   = GAP_LAST;
                    end else if (bit_d == DATA_FIRST) begin
                        state_d = S_DATA;
                    end else if (bit_d == PAR_IDX) begin
                        state_d = S_PAR;
                    end
                end
            end
            S_GAP: begin
                if (tmr_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic: registered outputs follow the state being entered.
    always_comb begin
        fifo_re_d   = (state_d == S_RD);
        frame_d     = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_PAR);
        ser_d       = frame_d & sr_d[FW-1];
        busy_d      = (state_d != S_IDLE);
        frame_cnt_d = frame_cnt_q;
        if (state_d == S_GAP && state_q != S_GAP) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    assign fifo_re_o   = fifo_re_q;
    assign ser_o       = ser_q;
    assign frame_o     = frame_q;
    assign busy_o      = busy_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_tstamp_serial_readout.sv
// Bench for tstamp_serial_readout: two instances (default timing, and
// READ_LAT=3 / BITDIV=3), a FIFO model per instance, and a frame-level model
// that expands each pop into the expected per-cycle output waveform.
module tb_tstamp_serial_readout;

    typedef struct packed {
        logic re;
        logic ser;
        logic frame;
        logic busy;
        logic inc;
    } exp_t;

    logic        clk;
    logic [1:0]  rst_a, en_a, empty_a;
    logic [15:0] data_a [2];
    logic [1:0]  re_w, ser_w, frame_w, busy_w;
    logic [15:0] cnt_w [2];

    // FIFO contents and pointers
    logic [15:0] fmem [2][1024];
    int          head_a [2];
    int          tail_a [2];
    int          pcnt [2];
    logic [15:0] pw [2];
    int          RLV [2];
    int          BDV [2];

    // Model state
    exp_t        seq [2][128];
    int          spos [2];
    int          slen [2];
    exp_t        cur [2];
    logic [15:0] mcnt [2];

    // Frame capture
    int          cyc;
    logic        fprev [2];
    logic [63:0] raw [2];
    logic [63:0] draw [2];
    int          flen [2];
    int          dlen [2];
    int          nframes [2];
    int          fstart [2];
    int          fgap [2];
    logic [7:0]  phist [2];
    int          nre [2];

    int nvec;
    int nmis;

    tstamp_serial_readout u0 (
        .clk(clk), .rst(rst_a[0]), .enable_i(en_a[0]), .fifo_data_i(data_a[0]),
        .fifo_empty_i(empty_a[0]), .fifo_re_o(re_w[0]), .ser_o(ser_w[0]),
        .frame_o(frame_w[0]), .busy_o(busy_w[0]), .frame_cnt_o(cnt_w[0])
    );

    tstamp_serial_readout #(.READ_LAT(3), .BITDIV(3)) u1 (
        .clk(clk), .rst(rst_a[1]), .enable_i(en_a[1]), .fifo_data_i(data_a[1]),
        .fifo_empty_i(empty_a[1]), .fifo_re_o(re_w[1]), .ser_o(ser_w[1]),
        .frame_o(frame_w[1]), .busy_o(busy_w[1]), .frame_cnt_o(cnt_w[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(logic r, logic s, logic f, logic b, logic i);
        exp_t e;
        e.re = r; e.ser = s; e.frame = f; e.busy = b; e.inc = i;
        return e;
    endfunction

    task automatic sput(input int g, input exp_t e);
        seq[g][slen[g]] = e;
        slen[g]++;
    endtask

    // Expand one popped word into every cycle it occupies on the outputs.
    task automatic build(input int g, input logic [15:0] w);
        logic [20:0] fb;
        fb = {4'b1011, w, ^w};
        slen[g] = 0;
        spos[g] = 0;
        sput(g, mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
        for (int k = 0; k < RLV[g]; k++) sput(g, mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        for (int b = 20; b >= 0; b--)
            for (int k = 0; k < BDV[g]; k++) sput(g, mk(1'b0, fb[b], 1'b1, 1'b1, 1'b0));
        for (int k = 0; k < 2 * BDV[g]; k++) sput(g, mk(1'b0, 1'b0, 1'b0, 1'b1, k == 0));
        sput(g, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic model_adv(input int g);
        if (rst_a[g]) begin
            slen[g] = 0;
            spos[g] = 0;
            cur[g]  = '0;
            mcnt[g] = '0;
        end else begin
            if (spos[g] >= slen[g] && en_a[g] && !empty_a[g]) build(g, fmem[g][head_a[g]]);
            if (spos[g] < slen[g]) begin
                cur[g] = seq[g][spos[g]];
                spos[g]++;
                if (cur[g].inc) mcnt[g]++;
            end else begin
                cur[g] = '0;
            end
        end
    endtask

    task automatic step();
        for (int g = 0; g < 2; g++) begin
            empty_a[g] = (head_a[g] >= tail_a[g]);
            model_adv(g);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("g%0d outputs", g),
                {re_w[g], ser_w[g], frame_w[g], busy_w[g], cnt_w[g]},
                {cur[g].re, cur[g].ser, cur[g].frame, cur[g].busy, mcnt[g]});
            if (frame_w[g]) begin
                if (!fprev[g]) begin
                    fgap[g]   = cyc - fstart[g];
                    fstart[g] = cyc;
                    raw[g]    = '0;
                    flen[g]   = 0;
                end
                raw[g] = {raw[g][62:0], ser_w[g]};
                flen[g]++;
            end else if (fprev[g]) begin
                draw[g] = raw[g];
                dlen[g] = flen[g];
                nframes[g]++;
                phist[g] = {phist[g][6:0], raw[g][0]};
            end
            fprev[g] = frame_w[g];
            if (re_w[g]) nre[g]++;
            // FIFO: popped word appears READ_LAT negedges later, garbage otherwise
            if (pcnt[g] == 1) data_a[g] = pw[g];
            else data_a[g] = 16'($urandom);
            if (pcnt[g] > 0) pcnt[g]--;
            if (re_w[g]) begin
                pw[g] = fmem[g][head_a[g]];
                head_a[g]++;
                pcnt[g] = RLV[g];
            end
        end
    endtask

    task automatic push(input int g, input logic [15:0] w);
        fmem[g][tail_a[g]] = w;
        tail_a[g]++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wait_frames(input int g, input int target, input int budget);
        int k;
        k = 0;
        while (nframes[g] < target && k < budget) begin
            step();
            k++;
        end
        chk($sformatf("g%0d frame done in time", g), 64'(nframes[g] >= target), 64'd1);
    endtask

    task automatic wait_start(input int g, input int budget);
        int k;
        k = 0;
        while (!frame_w[g] && k < budget) begin
            step();
            k++;
        end
        chk($sformatf("g%0d frame start in time", g), 64'(frame_w[g]), 64'd1);
    endtask

    function automatic logic [20:0] dec3(logic [63:0] r);
        logic [20:0] d;
        d = '0;
        for (int i = 0; i < 21; i++) d[20 - i] = r[62 - 3 * i];
        return d;
    endfunction

    initial begin
        int r0;
        int f0;
        int gl;
        nvec = 0; nmis = 0; cyc = 0;
        RLV[0] = 1; BDV[0] = 1;
        RLV[1] = 3; BDV[1] = 3;
        for (int g = 0; g < 2; g++) begin
            head_a[g] = 0; tail_a[g] = 0; pcnt[g] = 0; pw[g] = '0;
            spos[g] = 0; slen[g] = 0; cur[g] = '0; mcnt[g] = '0;
            fprev[g] = 1'b0; raw[g] = '0; draw[g] = '0; flen[g] = 0; dlen[g] = 0;
            nframes[g] = 0; fstart[g] = 0; fgap[g] = 0; phist[g] = '0; nre[g] = 0;
            data_a[g] = '0;
        end
        rst_a = 2'b11; en_a = 2'b00; empty_a = 2'b11;
        run(2);
        chk("g0 reset state", {re_w[0], ser_w[0], frame_w[0], busy_w[0], cnt_w[0]}, 64'd0);
        chk("g1 reset state", {re_w[1], ser_w[1], frame_w[1], busy_w[1], cnt_w[1]}, 64'd0);
        rst_a = 2'b00;

        // 5555 at defaults on g0, 0001 with BITDIV=3 on g1
        push(0, 16'h5555);
        push(1, 16'h0001);
        en_a = 2'b11;
        wait_frames(0, 1, 100);
        chk("s1 frame bits", draw[0], 64'(21'b1011_0101010101010101_0));
        chk("s1 frame length", 64'(dlen[0]), 64'd21);
        chk("s1 read pulses", 64'(nre[0]), 64'd1);
        chk("s1 frame count", 64'(cnt_w[0]), 64'd1);
        wait_frames(1, 1, 300);
        chk("s2 frame length", 64'(dlen[1]), 64'd63);
        chk("s2 frame bits", 64'(dec3(draw[1])), 64'(21'b1011_0000000000000001_1));
        gl = 0;
        while (busy_w[1] && !frame_w[1] && gl < 20) begin
            gl++;
            step();
        end
        chk("s2 gap length", 64'(gl), 64'd6);

        // READ_LAT=3 with garbage on the bus around the capture edge
        push(1, 16'h1234);
        wait_frames(1, 2, 300);
        chk("s3 frame bits", 64'(dec3(draw[1])), 64'(21'b1011_0001001000110100_1));

        // 8 preloaded words, back to back
        en_a[0] = 1'b0;
        rst_a[0] = 1'b1;
        step();
        rst_a[0] = 1'b0;
        for (int i = 0; i < 8; i++) push(0, 16'(i));
        f0 = nframes[0];
        r0 = nre[0];
        en_a[0] = 1'b1;
        wait_frames(0, f0 + 2, 100);
        chk("s4 spacing 1-2", 64'(fgap[0]), 64'd26);
        wait_frames(0, f0 + 8, 400);
        chk("s4 spacing 7-8", 64'(fgap[0]), 64'd26);
        chk("s4 parity bits", 64'(phist[0]), 64'(8'b01101001));
        run(60);
        chk("s4 read pulses", 64'(nre[0] - r0), 64'd8);
        chk("s4 frame count", 64'(cnt_w[0]), 64'd8);

        // enable dropped 5 cycles into an FFFF frame
        push(0, 16'hFFFF);
        push(0, 16'hA5A5);
        push(0, 16'h5A5A);
        wait_start(0, 50);
        run(5);
        en_a[0] = 1'b0;
        r0 = nre[0];
        f0 = nframes[0];
        wait_frames(0, f0 + 1, 100);
        chk("s5 frame bits", draw[0], 64'(21'b1011_1111111111111111_0));
        run(60);
        chk("s5 no read while disabled", 64'(nre[0]), 64'(r0));

        // reset during data bit 7 of A5A5
        en_a[0] = 1'b1;
        wait_start(0, 50);
        run(11);
        rst_a[0] = 1'b1;
        step();
        rst_a[0] = 1'b0;
        chk("s6 outputs after reset", {re_w[0], ser_w[0], frame_w[0], busy_w[0], cnt_w[0]}, 64'd0);
        f0 = nframes[0];
        wait_frames(0, f0 + 1, 100);
        chk("s6 next word sent", 64'(draw[0][16:1]), 64'h5A5A);

        // frame counter wrap
        en_a[0] = 1'b0;
        run(40);
        force u0.frame_cnt_d = 16'hFFFF;
        mcnt[0] = 16'hFFFF;
        step();
        release u0.frame_cnt_d;
        chk("s7 counter at max", 64'(cnt_w[0]), 64'hFFFF);
        push(0, 16'h00FF);
        en_a[0] = 1'b1;
        f0 = nframes[0];
        wait_frames(0, f0 + 1, 100);
        chk("s7 counter wrapped", 64'(cnt_w[0]), 64'd0);

        // random traffic, enable toggling and occasional resets
        for (int k = 0; k < 2500; k++) begin
            for (int g = 0; g < 2; g++) begin
                if ($urandom_range(0, 15) == 0 && tail_a[g] < 1000) push(g, 16'($urandom));
                if ($urandom_range(0, 39) == 0) en_a[g] = ~en_a[g];
                rst_a[g] = ($urandom_range(0, 499) == 0);
            end
            step();
        end
        rst_a = 2'b00;
        en_a = 2'b00;
        run(200);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/tstamp_serial_readout.md
Name: tstamp_serial_readout

Overview:
- Downstream consumer of the 16-bit timestamp sync FIFO.
- Pops one word at a time through the FIFO's read-enable/empty interface and frames it as header + data (MSB first) + even parity.
- Shifts each frame out serially on a single output-pad signal, with a frame-valid strobe.
- Cuts timestamp readout from 16 pads to 2.

Parameters:
- WORDWIDTH, 16, data bits per FIFO word and per frame.
- HDR_WIDTH, 4, header bit count.
- HEADER, 4'b1011, header pattern, sent MSB first.
- READ_LAT, 1, cycles from the edge that samples fifo_re_o high to valid fifo_data_i (legal 1..3).
- BITDIV, 1, clk cycles each serial bit is held (legal 1..16).
- GAP_BITS, 2, minimum idle bit periods between frames (legal 1..15).

Ports:
- clk  in  1  block clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- enable_i  in  1  readout enable.
- fifo_data_i  in  WORDWIDTH  FIFO read data.
- fifo_empty_i  in  1  FIFO empty flag.
- fifo_re_o  out  1  FIFO read enable, one-cycle pulse per word.
- ser_o  out  1  serial data to output pad.
- frame_o  out  1  high for every bit period of a frame.
- busy_o  out  1  high whenever state != IDLE.
- frame_cnt_o  out  16  count of completed frames.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). rst is sampled on the rising clk edge and overrides everything.
- Reset values:
  - fifo_re_o=0, ser_o=0, frame_o=0, busy_o=0, frame_cnt_o=0.
  - State=IDLE; shift register, bit counter and divider all 0.
- All outputs are registered; none is combinational from inputs.
- FSM states: IDLE, RD, WAIT, HDR, DATA, PAR, GAP.
  - IDLE: if enable_i=1 and fifo_empty_i=0 at edge N, go to RD.
  - RD: fifo_re_o=1 for exactly cycle N+1, then WAIT.
  - WAIT: hold READ_LAT cycles; on the final WAIT edge capture fifo_data_i into the shift register and compute parity = XOR of all data bits (even parity).
  - HDR: first header bit on ser_o at cycle N+2+READ_LAT; frame_o rises the same cycle.
  - Frame bit order: HDR_WIDTH header bits MSB first, then WORDWIDTH data bits MSB first (DATA state), then 1 parity bit (PAR state).
  - Each bit is held exactly BITDIV cycles. Frame length is (HDR_WIDTH+WORDWIDTH+1)*BITDIV cycles (21 at defaults).
  - GAP: ser_o=0, frame_o=0 for GAP_BITS*BITDIV cycles, then IDLE. frame_cnt_o increments by 1 on entry to GAP and wraps 16'hFFFF -> 0.
- Outside frames: ser_o=0, frame_o=0.
- Back-to-back throughput, FIFO never empty: one word per 1+1+READ_LAT+frame length+gap cycles (26 at defaults).
- fifo_re_o is never asserted while fifo_empty_i=1 was sampled in IDLE. fifo_empty_i is ignored in every other state.
- enable_i deasserted mid-frame: the current frame completes, including GAP, then the block stays in IDLE. enable_i low in RD/WAIT does not cancel the pop; that word is still sent.
- enable_i=1 with FIFO empty: remain in IDLE, busy_o=0, no read.
- rst asserted mid-frame: all outputs go to reset values on the next edge.
  - The popped word is discarded and not re-requested.
  - frame_cnt_o clears.
  - No partial frame resumes after reset release.
- fifo_data_i is sampled only on the final WAIT edge; changes at other times have no effect.

Test Plan:
- Reset then enable_i=1, FIFO holds 16'h5555, defaults:
  - fifo_re_o high exactly 1 cycle.
  - ser_o = 1011 0101010101010101 0 (parity 0), frame_o high 21 cycles.
  - frame_cnt_o becomes 1.
- Word 16'h0001, BITDIV=3:
  - each bit held 3 cycles; last data bit 1, parity bit 1.
  - frame_o high 63 cycles; GAP low 6 cycles.
- FIFO preloaded with 8 words (16'h0000..16'h0007), continuous enable:
  - 8 frames, consecutive frame starts 26 cycles apart.
  - Parity bits 0,1,1,0,1,0,0,1.
  - frame_cnt_o=8, then idle with fifo_empty_i=1 and no further fifo_re_o.
- enable_i dropped 5 cycles into a frame of 16'hFFFF:
  - frame completes with parity 0.
  - No new fifo_re_o while enable_i=0, although FIFO is non-empty.
- rst pulsed 1 cycle during DATA bit 7 of 16'hA5A5:
  - next cycle ser_o=0, frame_o=0, busy_o=0, frame_cnt_o=0.
  - After release the next frame carries the following FIFO word, not A5A5.
- READ_LAT=3: fifo_data_i changes to a garbage value before capture and to 16'h1234 at the capture edge → the frame transmits 16'h1234.
- frame_cnt_o forced past 16'hFFFF → wraps to 0 on the next frame.
